// File: rtl/zoom_coord_gen.sv
// Raster-order bilinear zoom DDA: emits source int coords, fractional weights and complements per destination pixel.
// Latency: first word registered one cycle after start; then one word per cycle; done one cycle after the last transfer.
// Backpressure: valid/ready; the word is held in registers while out_ready is low, and out_valid never depends on out_ready.
module zoom_coord_gen #(
    parameter int IMG_W = 12,
    parameter int FRA_W = 8
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   start,
    input  logic [IMG_W-1:0]       src_w,
    input  logic [IMG_W-1:0]       src_h,
    input  logic [IMG_W-1:0]       dst_w,
    input  logic [IMG_W-1:0]       dst_h,
    input  logic [IMG_W+FRA_W-1:0] step_x,
    input  logic [IMG_W+FRA_W-1:0] step_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IMG_W-1:0]       x_int,
    output logic [IMG_W-1:0]       y_int,
    output logic [FRA_W-1:0]       x_fra,
    output logic [FRA_W-1:0]       y_fra,
    output logic [FRA_W:0]         x_fra_inv,
    output logic [FRA_W:0]         y_fra_inv,
    output logic                   line_end,
    output logic                   frame_end,
    output logic                   busy,
    output logic                   done
);
    localparam int ACC_W = IMG_W + FRA_W;
    localparam logic [FRA_W:0] FRA_ONE = {1'b1, {FRA_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [IMG_W-1:0] ip;
        logic [FRA_W-1:0] fp;
        logic [FRA_W:0]   inv;
    } coord_t;

    state_t           state, state_nxt;
    logic [IMG_W-1:0] sw, sh, dw, dh;
    logic [ACC_W-1:0] stx, sty;
    logic [ACC_W-1:0] acc_x, acc_y, acc_x_nxt, acc_y_nxt;
    logic [IMG_W-1:0] ox, oy, ox_nxt, oy_nxt;
    logic             load;
    logic [IMG_W-1:0] sel_sw, sel_sh, sel_dw, sel_dh;
    coord_t           cx, cy;

    // Split accumulator into index/weight; past the last source pixel there is no right/bottom neighbour, so pin to it.
    function automatic coord_t map_coord(input logic [ACC_W-1:0] acc, input logic [IMG_W-1:0] src);
        coord_t           c;
        logic [IMG_W-1:0] lim;
        lim  = src - 1'b1;
        c.ip = acc[ACC_W-1:FRA_W];
        c.fp = acc[FRA_W-1:0];
        if (c.ip >= lim) begin
            c.ip = lim;
            c.fp = '0;
        end
        c.inv = FRA_ONE - {1'b0, c.fp};
        return c;
    endfunction

    // While idle the word for pixel (0,0) is built from the live inputs, since they are latched on that same edge.
    assign sel_sw = (state == IDLE) ? src_w : sw;
    assign sel_sh = (state == IDLE) ? src_h : sh;
    assign sel_dw = (state == IDLE) ? dst_w : dw;
    assign sel_dh = (state == IDLE) ? dst_h : dh;

    assign cx = map_coord(acc_x_nxt, sel_sw);
    assign cy = map_coord(acc_y_nxt, sel_sh);

    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // State register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, DDA stepping on each transfer, and the load strobe for the output word.
    always_comb begin
        state_nxt = state;
        acc_x_nxt = acc_x;
        acc_y_nxt = acc_y;
        ox_nxt    = ox;
        oy_nxt    = oy;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_x_nxt = '0;
                    acc_y_nxt = '0;
                    ox_nxt    = '0;
                    oy_nxt    = '0;
                    if (dst_w == '0 || dst_h == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                        load      = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (ox != dw - 1'b1) begin
                        ox_nxt    = ox + 1'b1;
                        acc_x_nxt = acc_x + stx;
                        load      = 1'b1;
                    end else if (oy != dh - 1'b1) begin
                        ox_nxt    = '0;
                        acc_x_nxt = '0;
                        oy_nxt    = oy + 1'b1;
                        acc_y_nxt = acc_y + sty;
                        load      = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame parameters, DDA state and the registered coordinate word.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sw        <= '0;
            sh        <= '0;
            dw        <= '0;
            dh        <= '0;
            stx       <= '0;
            sty       <= '0;
            acc_x     <= '0;
            acc_y     <= '0;
            ox        <= '0;
            oy        <= '0;
            x_int     <= '0;
            y_int     <= '0;
            x_fra     <= '0;
            y_fra     <= '0;
            x_fra_inv <= '0;
            y_fra_inv <= '0;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                sw  <= src_w;
                sh  <= src_h;
                dw  <= dst_w;
                dh  <= dst_h;
                stx <= step_x;
                sty <= step_y;
            end
            acc_x <= acc_x_nxt;
            acc_y <= acc_y_nxt;
            ox    <= ox_nxt;
            oy    <= oy_nxt;
            if (load) begin
                x_int     <= cx.ip;
                y_int     <= cy.ip;
                x_fra     <= cx.fp;
                y_fra     <= cy.fp;
                x_fra_inv <= cx.inv;
                y_fra_inv <= cy.inv;
                line_end  <= (ox_nxt == sel_dw - 1'b1);
                frame_end <= (ox_nxt == sel_dw - 1'b1) && (oy_nxt == sel_dh - 1'b1);
            end
        end
    end
endmodule
